// File: rtl/led_sequencer.sv
// LED pattern generator: divides clk into pattern steps, drives rotate/bounce/blink/count
// patterns gated by a global PWM brightness, plus a per-step heartbeat and step pulse.
module led_sequencer #(
   parameter int unsigned N_LEDS   = 4,
   parameter int unsigned TICK_DIV = 12_000_000,
   parameter int unsigned PWM_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [PWM_W-1:0]  brightness,
   output logic [N_LEDS-1:0] leds,
   output logic              heartbeat,
   output logic              step
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   logic [DIV_W-1:0]  div_cnt, div_cnt_n;
   logic [PWM_W-1:0]  pwm_cnt, pwm_cnt_n;
   logic [POS_W-1:0]  pos, pos_n;
   logic              dir, dir_n;          // 0 = moving up, 1 = moving down
   logic [N_LEDS-1:0] cnt, cnt_n;
   logic              blink, blink_n;
   mode_e             mode_q, mode_q_n;
   logic [N_LEDS-1:0] leds_n;
   logic              heartbeat_n;
   logic              step_n;

   logic              step_int;
   logic              mode_chg;
   logic              pwm_on;
   logic [N_LEDS-1:0] one_hot;
   logic [N_LEDS-1:0] pattern;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         pwm_cnt   <= '0;
         pos       <= '0;
         dir       <= 1'b0;
         cnt       <= '0;
         blink     <= 1'b0;
         mode_q    <= MODE_ROTATE;
         leds      <= '0;
         heartbeat <= 1'b0;
         step      <= 1'b0;
      end else begin
         div_cnt   <= div_cnt_n;
         pwm_cnt   <= pwm_cnt_n;
         pos       <= pos_n;
         dir       <= dir_n;
         cnt       <= cnt_n;
         blink     <= blink_n;
         mode_q    <= mode_q_n;
         leds      <= leds_n;
         heartbeat <= heartbeat_n;
         step      <= step_n;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      div_cnt_n   = div_cnt;
      pwm_cnt_n   = pwm_cnt + PWM_W'(1);
      pos_n       = pos;
      dir_n       = dir;
      cnt_n       = cnt;
      blink_n     = blink;
      mode_q_n    = mode_e'(mode);
      heartbeat_n = heartbeat;

      step_int = enable && (div_cnt == DIV_LAST);
      mode_chg = (mode_e'(mode) != mode_q);

      // A mode change restarts the pattern and swallows any coincident step
      if (mode_chg) begin
         div_cnt_n = '0;
         pos_n     = '0;
         dir_n     = 1'b0;
         cnt_n     = '0;
         blink_n   = 1'b0;
      end else if (enable) begin
         div_cnt_n = step_int ? '0 : div_cnt + DIV_W'(1);
         if (step_int) begin
            heartbeat_n = ~heartbeat;
            case (mode_q)
               MODE_ROTATE: pos_n = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
               MODE_BOUNCE: begin
                  if (N_LEDS == 1) begin
                     pos_n = '0;
                  end else if (!dir) begin
                     if (pos == POS_LAST) begin
                        dir_n = 1'b1;
                        pos_n = pos - POS_W'(1);
                     end else begin
                        pos_n = pos + POS_W'(1);
                     end
                  end else begin
                     if (pos == '0) begin
                        dir_n = 1'b0;
                        pos_n = POS_W'(1);
                     end else begin
                        pos_n = pos - POS_W'(1);
                     end
                  end
               end
               MODE_BLINK:  blink_n = ~blink;
               default:     cnt_n = cnt + N_LEDS'(1);
            endcase
         end
      end

      one_hot = N_LEDS'(1) << pos;
      case (mode_q)
         MODE_ROTATE, MODE_BOUNCE: pattern = one_hot;
         MODE_BLINK:               pattern = {N_LEDS{blink}};
         default:                  pattern = cnt;
      endcase

      pwm_on = (brightness == '1) || (pwm_cnt < brightness);
      leds_n = pattern & {N_LEDS{pwm_on}};
      step_n = step_int && !mode_chg;
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: step-count based reference model checked every cycle,
// plus directed literal expectations and randomized enable/mode/brightness/reset traffic.
module tb_led_sequencer;

   localparam int N  = 4;
   localparam int TD = 4;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b1;
   logic [1:0]    mode = 2'd0;
   logic [PW-1:0] brightness = '1;
   logic [N-1:0]  leds;
   logic          heartbeat;
   logic          step;

   led_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .PWM_W(PW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .brightness(brightness),
      .leds(leds), .heartbeat(heartbeat), .step(step)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Pattern as a function of steps taken since the last restart
   function automatic logic [N-1:0] pattern_of(input logic [1:0] md, input int k);
      int p;
      int sh;
      logic [N-1:0] r;
      case (md)
         2'd0: r = N'(1) << (k % N);
         2'd1: begin
            p  = k % (2 * N - 2);
            sh = (p < N) ? p : (2 * N - 2 - p);
            r  = N'(1) << sh;
         end
         2'd2: r = ((k % 2) == 1) ? '1 : '0;
         default: r = N'(k % (1 << N));
      endcase
      return r;
   endfunction

   // Inputs as seen at the last rising edge
   logic          s_rst = 1'b0, s_en = 1'b0, s_seen = 1'b0;
   logic [1:0]    s_mode = 2'd0;
   logic [PW-1:0] s_br = '0;

   always @(posedge clk) begin
      s_rst  <= rst;
      s_en   <= enable;
      s_mode <= mode;
      s_br   <= brightness;
      s_seen <= 1'b1;
   end

   int           m_div = 0, m_k = 0, m_pwm = 0;
   logic [1:0]   m_mode_q = 2'd0;
   logic [N-1:0] e_leds = '0;
   logic         e_hb = 1'b0, e_step = 1'b0;
   bit           m_valid = 1'b0;

   // Reference model update followed by the per-cycle comparison
   always @(negedge clk) begin
      bit on, st, chg;
      if (s_seen) begin
         if (s_rst) begin
            m_div = 0; m_k = 0; m_pwm = 0; m_mode_q = 2'd0;
            e_leds = '0; e_hb = 1'b0; e_step = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            on     = (s_br == '1) || (m_pwm < int'(s_br));
            e_leds = on ? pattern_of(m_mode_q, m_k) : '0;
            st     = s_en && (m_div == TD - 1);
            chg    = (s_mode != m_mode_q);
            e_step = st && !chg;
            if (e_step) e_hb = ~e_hb;
            if (chg) begin
               m_k = 0; m_div = 0;
            end else if (s_en) begin
               m_div = (m_div + 1) % TD;
               if (st) m_k++;
            end
            m_mode_q = s_mode;
            m_pwm    = (m_pwm + 1) % (1 << PW);
         end
         if (m_valid) begin
            check("model_leds", 32'(leds), 32'(e_leds));
            check("model_heartbeat", 32'(heartbeat), 32'(e_hb));
            check("model_step", 32'(step), 32'(e_step));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   logic [N-1:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [N-1:0] bnc_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};

   initial begin
      int on_cnt;

      // Rotate from reset with literal expectations
      rst = 1'b1; mode = 2'd0; enable = 1'b1; brightness = '1;
      tick();
      check("rst_leds", 32'(leds), 32'h0);
      check("rst_step", 32'(step), 32'h0);
      check("rst_heartbeat", 32'(heartbeat), 32'h0);
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n % 4 == 1) check("rotate_leds", 32'(leds), 32'(rot_exp[n / 4]));
         if (n == 4) begin
            check("rotate_step_pulse", 32'(step), 32'h1);
            check("rotate_hb_first", 32'(heartbeat), 32'h1);
         end
         if (n == 5) check("rotate_step_single", 32'(step), 32'h0);
         if (n == 8) check("rotate_hb_second", 32'(heartbeat), 32'h0);
      end

      // Bounce from reset: first edge after release restarts the pattern
      rst = 1'b1; mode = 2'd1;
      tick(); tick();
      rst = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (n % 4 == 2) check("bounce_leds", 32'(leds), 32'(bnc_exp[n / 4]));
      end

      // PWM duty with the pattern frozen at 0001
      rst = 1'b1; mode = 2'd0; enable = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int b = 0; b < 4; b++) begin
         brightness = PW'(b);
         on_cnt = 0;
         repeat (8) begin
            tick();
            if (leds != '0) on_cnt++;
         end
         check("pwm_duty", 32'(on_cnt), (b == 3) ? 32'd8 : 32'(2 * b));
         check("pwm_frozen_step", 32'(step), 32'h0);
      end

      // Reset coinciding with a step edge and a mode change
      rst = 1'b1; mode = 2'd0; enable = 1'b1; brightness = '1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1; mode = 2'd2;
      tick();
      check("rst_wins_leds", 32'(leds), 32'h0);
      check("rst_wins_step", 32'(step), 32'h0);
      check("rst_wins_heartbeat", 32'(heartbeat), 32'h0);
      rst = 1'b0;
      repeat (40) tick();

      // Count through a full wrap, then rotate with an enable freeze
      mode = 2'd3;
      repeat (80) tick();
      mode = 2'd0;
      repeat (6) tick();
      enable = 1'b0;
      repeat (10) tick();
      enable = 1'b1;
      repeat (12) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst    = (($urandom % 100) == 0);
         enable = (($urandom % 8) != 0);
         if (($urandom % 40) == 0) mode = 2'($urandom);
         if (($urandom % 20) == 0) brightness = PW'($urandom);
      end
      rst = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
